// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core-to-Wishbone memory arbiter.
package core_bus_pkg;

    // Arbiter sequencing states: idle, bus cycle for data, bus cycle for fetch, response
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_D = 2'd1,
        BUS_I = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // funct3 size codes as presented on d_op
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // addi x0,x0,0 handed back to the core when a fetch fails
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/wb_lane_align.sv
// Maps a data access size and byte offset onto Wishbone byte lanes,
// replicates store data across the lanes and flags misaligned accesses.
module wb_lane_align
    import core_bus_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    // Size decode; unknown size codes are treated as full words
    always_comb begin
        sel_o        = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = |addr_i;
        case (op_i)
            OP_B, OP_BU: begin
                sel_o        = 4'b0001 << addr_i;
                wdata_o      = {4{wdata_i[7:0]}};
                misaligned_o = 1'b0;
            end
            OP_H, OP_HU: begin
                sel_o        = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_i[0];
            end
            default: begin
                sel_o        = 4'b1111;
                wdata_o      = wdata_i;
                misaligned_o = |addr_i;
            end
        endcase
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one Wishbone B4 classic master between the instruction-fetch and
// data ports of the core. Each transfer runs IDLE -> BUS_x -> RESP, so a
// zero-wait slave yields an ack two cycles after the request.
module core_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DATA_FIRST     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_err,
    output logic        stall_pipl,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    import core_bus_pkg::*;

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      ifRdata_q, ifRdata_d;
    logic [31:0]      dRdata_q, dRdata_d;
    logic             ifAck_q, ifAck_d;
    logic             dAck_q, dAck_d;
    logic             err_q, err_d;
    logic             dataLast_q, dataLast_d;

    logic             pickData;
    logic [3:0]       alignSel;
    logic [31:0]      alignWdata;
    logic             alignMisaligned;
    logic             unusedIfAddrLow;

    // Fetches are word aligned by construction, so the low bits carry no information
    assign unusedIfAddrLow = ^if_addr[1:0];

    wb_lane_align uLaneAlign (
        .op_i         (d_op),
        .addr_i       (d_addr[1:0]),
        .wdata_i      (d_wdata),
        .sel_o        (alignSel),
        .wdata_o      (alignWdata),
        .misaligned_o (alignMisaligned)
    );

    // Next-state, bus latching and response generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        ifRdata_d  = ifRdata_q;
        dRdata_d   = dRdata_q;
        ifAck_d    = 1'b0;
        dAck_d     = 1'b0;
        err_d      = 1'b0;
        dataLast_d = dataLast_q;
        pickData   = 1'b0;

        case (state_q)
            IDLE: begin
                // A data transfer just served yields to a waiting fetch so fetch cannot starve
                pickData = d_req & (~if_req | ((DATA_FIRST != 0) & ~dataLast_q));
                if (pickData) begin
                    dataLast_d = 1'b1;
                    if (alignMisaligned) begin
                        state_d  = RESP;
                        dAck_d   = 1'b1;
                        err_d    = 1'b1;
                        dRdata_d = 32'd0;
                    end else begin
                        state_d = BUS_D;
                        cyc_d   = 1'b1;
                        we_d    = d_we;
                        adr_d   = {d_addr[31:2], 2'b00};
                        dat_d   = alignWdata;
                        sel_d   = alignSel;
                        cnt_d   = '0;
                    end
                end else if (if_req) begin
                    dataLast_d = 1'b0;
                    state_d    = BUS_I;
                    cyc_d      = 1'b1;
                    we_d       = 1'b0;
                    adr_d      = {if_addr[31:2], 2'b00};
                    dat_d      = 32'd0;
                    sel_d      = 4'b1111;
                    cnt_d      = '0;
                end
            end

            BUS_D, BUS_I: begin
                if (wb_err_i || (!wb_ack_i && cnt_q == CNT_LAST)) begin
                    state_d = RESP;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == BUS_D) begin
                        dAck_d   = 1'b1;
                        dRdata_d = 32'd0;
                    end else begin
                        ifAck_d   = 1'b1;
                        ifRdata_d = NOP_INSTR;
                    end
                end else if (wb_ack_i) begin
                    state_d = RESP;
                    cyc_d   = 1'b0;
                    if (state_q == BUS_D) begin
                        dAck_d   = 1'b1;
                        dRdata_d = wb_dat_i;
                    end else begin
                        ifAck_d   = 1'b1;
                        ifRdata_d = wb_dat_i;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            ifRdata_q  <= 32'd0;
            dRdata_q   <= 32'd0;
            ifAck_q    <= 1'b0;
            dAck_q     <= 1'b0;
            err_q      <= 1'b0;
            dataLast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            ifRdata_q  <= ifRdata_d;
            dRdata_q   <= dRdata_d;
            ifAck_q    <= ifAck_d;
            dAck_q     <= dAck_d;
            err_q      <= err_d;
            dataLast_q <= dataLast_d;
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign if_rdata   = ifRdata_q;
    assign if_ack     = ifAck_q;
    assign d_rdata    = dRdata_q;
    assign d_ack      = dAck_q;
    assign bus_err    = err_q;
    assign stall_pipl = (if_req & ~ifAck_q) | (d_req & ~dAck_q);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter (timeout shortened to 8 cycles).
module tb_core_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        bus_err;
    logic        stall_pipl;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int assertCount;
    int failCount;

    core_mem_arbiter #(
        .TIMEOUT_CYCLES (8),
        .DATA_FIRST     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_op       (d_op),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .bus_err    (bus_err),
        .stall_pipl (stall_pipl),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge; slave strobes are single-cycle
    task automatic nextCycle();
        @(posedge clk);
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input logic dReq, input logic dWe, input logic [2:0] dOp,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata,
                                 input logic ifReq, input logic [31:0] ifAddr);
        d_req   = dReq;
        d_we    = dWe;
        d_op    = dOp;
        d_addr  = dAddr;
        d_wdata = dWdata;
        if_req  = ifReq;
        if_addr = ifAddr;
        #1;
    endtask

    task automatic slaveAck(input logic [31:0] dat);
        wb_dat_i = dat;
        wb_ack_i = 1'b1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset    = 1'b1;
        wb_dat_i = 32'd0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        nextCycle();

        $display("[TB] reset state");
        checkOutput("rst_cyc",   {31'd0, wb_cyc_o},   32'd0);
        checkOutput("rst_stb",   {31'd0, wb_stb_o},   32'd0);
        checkOutput("rst_ifack", {31'd0, if_ack},     32'd0);
        checkOutput("rst_dack",  {31'd0, d_ack},      32'd0);
        checkOutput("rst_err",   {31'd0, bus_err},    32'd0);
        checkOutput("rst_stall", {31'd0, stall_pipl}, 32'd0);
        checkOutput("rst_adr",   wb_adr_o,            32'd0);
        checkOutput("rst_sel",   {28'd0, wb_sel_o},   32'd0);
        reset = 1'b0;
        nextCycle();

        $display("[TB] fetch only, zero-wait slave");
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, 32'h100);
        checkOutput("f_stallN",  {31'd0, stall_pipl}, 32'd1);
        checkOutput("f_cycN",    {31'd0, wb_cyc_o},   32'd0);
        nextCycle();
        checkOutput("f_cyc1",    {31'd0, wb_cyc_o},   32'd1);
        checkOutput("f_stb1",    {31'd0, wb_stb_o},   32'd1);
        checkOutput("f_adr1",    wb_adr_o,            32'h100);
        checkOutput("f_sel1",    {28'd0, wb_sel_o},   32'hF);
        checkOutput("f_we1",     {31'd0, wb_we_o},    32'd0);
        checkOutput("f_ack1",    {31'd0, if_ack},     32'd0);
        checkOutput("f_stall1",  {31'd0, stall_pipl}, 32'd1);
        slaveAck(32'h0050_0093);
        nextCycle();
        checkOutput("f_ack2",    {31'd0, if_ack},     32'd1);
        checkOutput("f_rdata2",  if_rdata,            32'h0050_0093);
        checkOutput("f_stall2",  {31'd0, stall_pipl}, 32'd0);
        checkOutput("f_cyc2",    {31'd0, wb_cyc_o},   32'd0);
        checkOutput("f_err2",    {31'd0, bus_err},    32'd0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'h100);
        nextCycle();
        checkOutput("f_ack3",    {31'd0, if_ack},     32'd0);

        $display("[TB] simultaneous requests, data first then fetch");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h3000, 32'd0, 1'b1, 32'h104);
        nextCycle();
        checkOutput("a_adr1",    wb_adr_o,            32'h3000);
        checkOutput("a_cyc1",    {31'd0, wb_cyc_o},   32'd1);
        slaveAck(32'hDEAD_BEEF);
        nextCycle();
        checkOutput("a_dack2",   {31'd0, d_ack},      32'd1);
        checkOutput("a_drd2",    d_rdata,             32'hDEAD_BEEF);
        checkOutput("a_ifack2",  {31'd0, if_ack},     32'd0);
        checkOutput("a_stall2",  {31'd0, stall_pipl}, 32'd1);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h3004, 32'd0, 1'b1, 32'h104);
        nextCycle();
        checkOutput("a_cyc3",    {31'd0, wb_cyc_o},   32'd0);
        nextCycle();
        checkOutput("a_cyc4",    {31'd0, wb_cyc_o},   32'd1);
        checkOutput("a_adr4",    wb_adr_o,            32'h104);
        slaveAck(32'h00A0_0113);
        nextCycle();
        checkOutput("a_ifack5",  {31'd0, if_ack},     32'd1);
        checkOutput("a_ifrd5",   if_rdata,            32'h00A0_0113);
        checkOutput("a_dack5",   {31'd0, d_ack},      32'd0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h3004, 32'd0, 1'b0, 32'h104);
        nextCycle();
        nextCycle();
        checkOutput("a_adr7",    wb_adr_o,            32'h3004);
        checkOutput("a_cyc7",    {31'd0, wb_cyc_o},   32'd1);
        slaveAck(32'h1234_5678);
        nextCycle();
        checkOutput("a_dack8",   {31'd0, d_ack},      32'd1);
        checkOutput("a_drd8",    d_rdata,             32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();

        $display("[TB] store byte at offset 3");
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h2003, 32'h0000_00AB, 1'b0, 32'd0);
        nextCycle();
        checkOutput("sb_sel",    {28'd0, wb_sel_o},   32'h8);
        checkOutput("sb_dat",    wb_dat_o,            32'hABAB_ABAB);
        checkOutput("sb_adr",    wb_adr_o,            32'h2000);
        checkOutput("sb_we",     {31'd0, wb_we_o},    32'd1);
        slaveAck(32'd0);
        nextCycle();
        checkOutput("sb_dack",   {31'd0, d_ack},      32'd1);
        checkOutput("sb_err",    {31'd0, bus_err},    32'd0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();

        $display("[TB] store half at upper half");
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h2002, 32'h1234_BEEF, 1'b0, 32'd0);
        nextCycle();
        checkOutput("sh_sel",    {28'd0, wb_sel_o},   32'hC);
        checkOutput("sh_dat",    wb_dat_o,            32'hBEEF_BEEF);
        slaveAck(32'd0);
        nextCycle();
        checkOutput("sh_dack",   {31'd0, d_ack},      32'd1);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();

        $display("[TB] misaligned word store");
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h2002, 32'h5555_5555, 1'b0, 32'd0);
        nextCycle();
        checkOutput("mis_cyc",   {31'd0, wb_cyc_o},   32'd0);
        checkOutput("mis_dack",  {31'd0, d_ack},      32'd1);
        checkOutput("mis_err",   {31'd0, bus_err},    32'd1);
        checkOutput("mis_drd",   d_rdata,             32'd0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("mis_dack2", {31'd0, d_ack},      32'd0);
        checkOutput("mis_err2",  {31'd0, bus_err},    32'd0);
        checkOutput("mis_cyc2",  {31'd0, wb_cyc_o},   32'd0);

        $display("[TB] fetch timeout");
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, 32'h200);
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            checkOutput($sformatf("to_cyc%0d", i), {31'd0, wb_cyc_o}, 32'd1);
        end
        nextCycle();
        checkOutput("to_cyc9",   {31'd0, wb_cyc_o},   32'd0);
        checkOutput("to_ifack",  {31'd0, if_ack},     32'd1);
        checkOutput("to_err",    {31'd0, bus_err},    32'd1);
        checkOutput("to_rdata",  if_rdata,            32'h0000_0013);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("to_err2",   {31'd0, bus_err},    32'd0);

        $display("[TB] reset during data bus cycle");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h4000, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("rb_cyc1",   {31'd0, wb_cyc_o},   32'd1);
        reset = 1'b1;
        nextCycle();
        checkOutput("rb_cyc2",   {31'd0, wb_cyc_o},   32'd0);
        checkOutput("rb_dack2",  {31'd0, d_ack},      32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("rb_dack3",  {31'd0, d_ack},      32'd0);
        checkOutput("rb_cyc3",   {31'd0, wb_cyc_o},   32'd0);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h4001, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("rb_cyc4",   {31'd0, wb_cyc_o},   32'd1);
        checkOutput("rb_sel4",   {28'd0, wb_sel_o},   32'h2);
        checkOutput("rb_adr4",   wb_adr_o,            32'h4000);
        slaveAck(32'h0000_AA00);
        nextCycle();
        checkOutput("rb_dack5",  {31'd0, d_ack},      32'd1);
        checkOutput("rb_drd5",   d_rdata,             32'h0000_AA00);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'd0);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one Wishbone B4 classic master port between the rv32i core's instruction-fetch port and data-memory port.
- Sequences each transfer as request -> bus cycle -> response.
- Generates byte-lane selects and enforces alignment.
- Drives the core's stall_pipl input and bounds every bus cycle with a timeout.
- Sits between the core top and the SoC Wishbone interconnect.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a bus cycle may wait for wb_ack_i before it is aborted.
- DATA_FIRST, 1: when 1, a data request wins simultaneous arbitration; when 0, fetch wins.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held until if_ack
- if_addr  input  32  fetch address (word aligned)
- if_rdata  output  32  fetched instruction
- if_ack  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request (load or store); held until d_ack
- d_we  input  1  1 = store
- d_op  input  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- d_addr  input  32  data byte address
- d_wdata  input  32  store data, right-justified
- d_rdata  output  32  raw 32-bit bus word; extension is done in the core
- d_ack  output  1  one-cycle data completion pulse
- bus_err  output  1  one-cycle pulse on misalignment, timeout or wb_err_i
- stall_pipl  output  1  pipeline stall to the core
- wb_cyc_o  output  1  Wishbone cycle
- wb_stb_o  output  1  Wishbone strobe
- wb_we_o  output  1  Wishbone write enable
- wb_adr_o  output  32  Wishbone address, word aligned ([1:0]=00)
- wb_dat_o  output  32  Wishbone write data
- wb_sel_o  output  4  Wishbone byte lanes
- wb_dat_i  input  32  Wishbone read data
- wb_ack_i  input  1  Wishbone acknowledge
- wb_err_i  input  1  Wishbone error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-cycle drops cyc/stb at the next edge; the pending request gets no ack.
- FSM states: IDLE, BUS_D, BUS_I, RESP.
- IDLE:
  - d_req and if_req both high: go to BUS_D if DATA_FIRST, else BUS_I.
  - Only one request high: go to that request's BUS state.
  - Misaligned data request (H with addr[0]=1, or W with addr[1:0]!=0): go straight to RESP with d_ack, bus_err, d_rdata=0. No bus cycle is issued.
- BUS_x:
  - wb_cyc_o and wb_stb_o are registered and high for the whole state.
  - Address, data, sel and we are latched on entry and held stable.
  - On wb_ack_i: latch wb_dat_i and go to RESP.
  - On wb_err_i, or when the counter reaches TIMEOUT_CYCLES-1: go to RESP with bus_err. Read data is 0 for data, or 32'h00000013 (NOP) for fetch.
  - wb_ack_i and wb_err_i in the same cycle: err wins.
- RESP:
  - Exactly one cycle: the owner's ack is high and rdata is valid.
  - Returns to IDLE; arbitration is re-evaluated next cycle.
- Latency: with a zero-wait slave that acks in the first BUS cycle, request at cycle N gives ack at N+2. Back-to-back throughput is one transfer per 3 cycles.
- Fairness: after a data transfer, a still-pending fetch is served next even if d_req is high again, so fetch cannot starve.
- Lanes:
  - B: sel = 1 << addr[1:0]; wdata byte replicated to all 4 lanes.
  - H: sel = addr[1] ? 1100 : 0011; wdata half replicated.
  - W: sel = 1111.
  - Reads use the same sel as the corresponding size.
- stall_pipl = (if_req & ~if_ack) | (d_req & ~d_ack). It is combinational from registered state.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to BUS_x; saturates and never wraps.

Decomposition:
- Package core_bus_pkg holds:
  - the state enum;
  - the d_op size localparams;
  - NOP_INSTR = 32'h00000013.
- One natural sub-module: wb_lane_align, combinational. It maps d_op, addr[1:0] and wdata to sel, replicated wdata and a misaligned flag.

Test Plan:
1. Fetch only, if_addr=0x100, slave acks in 1 cycle with 0x00500093 -> if_ack at N+2, if_rdata=0x00500093, stall_pipl high N..N+1.
2. d_req and if_req in the same cycle, DATA_FIRST=1 -> BUS_D first, then BUS_I without re-serving data, even if d_req is re-raised.
3. SB with d_addr=0x2003, d_wdata=0xAB -> wb_sel_o=1000, wb_dat_o=0xABABABAB, wb_adr_o=0x2000.
4. SW with d_addr=0x2002 -> no wb_cyc_o, d_ack and bus_err at N+1.
5. Slave never acks a fetch, TIMEOUT_CYCLES=8 -> cyc drops after 8 cycles, if_rdata=0x00000013, bus_err pulse.
6. reset asserted during BUS_D -> wb_cyc_o=0 at the next edge, no d_ack; a new request after reset completes normally.
